// File: rtl/tick_event_counter_pkg.sv
// Shared state encoding and BCD helper for the tick event counter.
package tick_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int BCD_MAX_DIGITS = 8;

    // Packs a non-negative integer into up to eight BCD digits, digit 0 in [3:0].
    function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input int value);
        logic [4*BCD_MAX_DIGITS-1:0] packed_bcd;
        int                          rest;
        packed_bcd = '0;
        rest       = value;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            packed_bcd[4*i +: 4] = 4'(rest % 10);
            rest                 = rest / 10;
        end
        return packed_bcd;
    endfunction

endpackage

// File: rtl/tick_event_counter_bcd_digit.sv
// One decade of the BCD counter: mod-10 register with carry out on 9 -> 0.
module bcd_digit (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] q_o,
    output logic       carry_o
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = 4'd0;
        end else if (inc_i) begin
            q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o     = q_q;
    assign carry_o = inc_i && (q_q == 4'd9);

endmodule

// File: rtl/tick_event_counter.sv
// Synchronises the divided clock, turns its rising edges into ticks and counts
// them in a run/pause/clear controlled BCD counter.
//   state | meaning
//   IDLE  | stopped, count cleared or never started
//   RUN   | ticks increment the count
//   PAUSE | ticks still pulse, count held
module tick_event_counter
    import tick_counter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIGITS      = 2,
    parameter int MAX_COUNT   = 59
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                div_in_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                clear_i,
    output logic                tick_o,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                wrap_o,
    output logic                running_o
);

    localparam logic [4*BCD_MAX_DIGITS-1:0] MAX_BCD_FULL = to_bcd(MAX_COUNT);
    localparam logic [4*DIGITS-1:0]         MAX_BCD      = MAX_BCD_FULL[4*DIGITS-1:0];

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tick_q;
    logic                   synced;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], div_in_i};
            prev_q <= synced;
            tick_q <= synced & ~prev_q;
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    state_e state_q;
    state_e state_d;
    logic   running_q;

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_i) state_d = RUN;
                RUN:     if (stop_i)  state_d = PAUSE;
                PAUSE:   if (start_i) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
        end
    end

    // Counting uses the current state, so a tick alongside stop still counts
    // and a tick alongside start does not.
    logic                cnt_inc;
    logic                at_max;
    logic                wrap_d;
    logic                digit_clr;
    logic [DIGITS:0]     carry_chain;
    logic [4*DIGITS-1:0] bcd_w;
    logic                wrap_q;

    assign cnt_inc        = tick_q && (state_q == RUN) && !clear_i;
    assign at_max         = (bcd_w == MAX_BCD);
    assign wrap_d         = cnt_inc && (at_max || carry_chain[DIGITS]);
    assign digit_clr      = clear_i || wrap_d;
    assign carry_chain[0] = cnt_inc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .inc_i   (carry_chain[g]),
            .clr_i   (digit_clr),
            .q_o     (bcd_w[4*g +: 4]),
            .carry_o (carry_chain[g+1])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign tick_o    = tick_q;
    assign bcd_o     = bcd_w;
    assign wrap_o    = wrap_q;
    assign running_o = running_q;

endmodule

// File: tb/tb_tick_event_counter.sv
// Directed bench for tick_event_counter with a tick-driven scoreboard monitor.
module tb_tick_event_counter;

    logic       clk;
    logic       rst_n;
    logic       div_in;
    logic       start;
    logic       stop;
    logic       clear;
    logic       tick_o;
    logic [7:0] bcd_o;
    logic       wrap_o;
    logic       running_o;

    tick_event_counter #(
        .SYNC_STAGES (2),
        .DIGITS      (2),
        .MAX_COUNT   (59)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .div_in_i  (div_in),
        .start_i   (start),
        .stop_i    (stop),
        .clear_i   (clear),
        .tick_o    (tick_o),
        .bcd_o     (bcd_o),
        .wrap_o    (wrap_o),
        .running_o (running_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] bcd;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   tick_seen   = 0;
    int   wrap_seen   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd8(input int k);
        return 8'(((k / 10) % 10) * 16 + (k % 10));
    endfunction

    // Each tick must be matched by a queued expectation; bcd/wrap settle one cycle later.
    always begin
        @(negedge clk);
        if (rst_n && tick_o) begin
            tick_seen++;
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("tick_expected", 32'd0, 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bcd_after_tick", 32'(bcd_o), 32'(mon_e.bcd));
                chk("wrap_after_tick", 32'(wrap_o), 32'(mon_e.wrap));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && wrap_o) wrap_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic s, input logic p, input logic c);
        start = s;
        stop  = p;
        clear = c;
        step();
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic div_pulse(input logic [7:0] eb, input logic ew);
        exp_q.push_back('{bcd: eb, wrap: ew});
        div_in = 1'b1;
        repeat (16) step();
        div_in = 1'b0;
        repeat (16) step();
    endtask

    initial begin
        int   tick_at;
        int   n_ticks;
        logic tick_any;
        int   t0;
        int   w0;

        rst_n  = 1'b0;
        div_in = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        clear  = 1'b0;

        // Reset held while div_in toggles, then release with div_in high
        tick_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            div_in   = ~div_in;
            tick_any = tick_any | tick_o;
        end
        chk("reset_tick", 32'(tick_any), 32'd0);
        chk("reset_bcd", 32'(bcd_o), 32'd0);
        chk("reset_running", 32'(running_o), 32'd0);
        chk("reset_wrap", 32'(wrap_o), 32'd0);
        div_in = 1'b1;
        exp_q.push_back('{bcd: 8'h00, wrap: 1'b0});
        rst_n   = 1'b1;
        tick_at = 0;
        n_ticks = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (tick_o) begin
                tick_at = k;
                n_ticks++;
            end
        end
        chk("release_tick_pos", 32'(tick_at), 32'd3);
        chk("release_tick_cnt", 32'(n_ticks), 32'd1);
        div_in = 1'b0;
        repeat (4) step();

        // Rise-to-tick latency in RUN, no tick on fall
        ctl(0, 0, 1);
        ctl(1, 0, 0);
        step();
        chk("start_running", 32'(running_o), 32'd1);
        exp_q.push_back('{bcd: 8'h01, wrap: 1'b0});
        div_in  = 1'b1;
        tick_at = 0;
        n_ticks = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (tick_o) begin
                tick_at = k;
                n_ticks++;
            end
        end
        chk("rise_tick_pos", 32'(tick_at), 32'd3);
        chk("rise_tick_cnt", 32'(n_ticks), 32'd1);
        repeat (10) step();
        div_in   = 1'b0;
        tick_any = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            tick_any = tick_any | tick_o;
        end
        chk("fall_no_tick", 32'(tick_any), 32'd0);
        repeat (10) step();

        // Full count 00..59 then wrap to 00
        ctl(0, 0, 1);
        ctl(1, 0, 0);
        w0 = wrap_seen;
        for (int k = 1; k <= 60; k++) begin
            div_pulse(to_bcd8(k % 60), (k == 60));
        end
        chk("wrap_once", 32'(wrap_seen - w0), 32'd1);
        chk("bcd_after_wrap", 32'(bcd_o), 32'h00);

        // Pause at 17 holds the count while ticks still pulse
        ctl(0, 0, 1);
        ctl(1, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            div_pulse(to_bcd8(k), 1'b0);
        end
        chk("bcd_before_pause", 32'(bcd_o), 32'h17);
        ctl(0, 1, 0);
        chk("pause_running", 32'(running_o), 32'd0);
        t0 = tick_seen;
        for (int k = 0; k < 5; k++) begin
            div_pulse(8'h17, 1'b0);
        end
        chk("pause_ticks", 32'(tick_seen - t0), 32'd5);
        chk("pause_bcd", 32'(bcd_o), 32'h17);
        ctl(1, 0, 0);
        div_pulse(8'h18, 1'b0);
        chk("resume_bcd", 32'(bcd_o), 32'h18);

        // Tick coincident with stop is counted
        ctl(0, 0, 1);
        ctl(1, 0, 0);
        exp_q.push_back('{bcd: 8'h01, wrap: 1'b0});
        div_in = 1'b1;
        repeat (3) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("tickstop_running", 32'(running_o), 32'd0);
        repeat (12) step();
        div_in = 1'b0;
        repeat (16) step();
        chk("tickstop_bcd", 32'(bcd_o), 32'h01);

        // Tick coincident with start from IDLE is not counted
        ctl(0, 0, 1);
        exp_q.push_back('{bcd: 8'h00, wrap: 1'b0});
        div_in = 1'b1;
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("tickstart_running", 32'(running_o), 32'd1);
        repeat (12) step();
        div_in = 1'b0;
        repeat (16) step();
        chk("tickstart_bcd", 32'(bcd_o), 32'h00);

        // Tick coincident with clear is dropped
        div_pulse(8'h01, 1'b0);
        exp_q.push_back('{bcd: 8'h00, wrap: 1'b0});
        div_in = 1'b1;
        repeat (3) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("tickclear_running", 32'(running_o), 32'd0);
        repeat (12) step();
        div_in = 1'b0;
        repeat (16) step();
        chk("tickclear_bcd", 32'(bcd_o), 32'h00);

        // clear + stop + start together: clear wins
        ctl(1, 0, 0);
        div_pulse(8'h01, 1'b0);
        ctl(1, 1, 1);
        chk("allreq_running", 32'(running_o), 32'd0);
        chk("allreq_bcd", 32'(bcd_o), 32'h00);

        // Asynchronous reset between clock edges at 42
        ctl(1, 0, 0);
        for (int k = 1; k <= 42; k++) begin
            div_pulse(to_bcd8(k), 1'b0);
        end
        chk("bcd_before_areset", 32'(bcd_o), 32'h42);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_bcd", 32'(bcd_o), 32'h00);
        chk("areset_running", 32'(running_o), 32'd0);
        #4;
        rst_n = 1'b1;
        step();
        ctl(1, 0, 0);
        div_pulse(8'h01, 1'b0);
        chk("post_reset_bcd", 32'(bcd_o), 32'h01);

        repeat (4) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
